// File: rtl/ecc_pkg.sv
// Shared SECDED helpers: code sizing and the codeword position map used by
// both the encoder and the decoder.
package ecc_pkg;

  typedef enum logic [1:0] {
    ECC_CLEAN  = 2'd0,
    ECC_CORR   = 2'd1,
    ECC_UNCORR = 2'd2
  } ecc_stat_e;

  // smallest r with 2^r >= dw + r + 1
  function automatic int ecc_pw(input int dw);
    int r;
    r = 0;
    for (int i = 7; i >= 1; i--)
      if ((1 << i) >= dw + i + 1) r = i;
    return r;
  endfunction

  function automatic int ecc_cw(input int dw);
    return dw + ecc_pw(dw) + 1;
  endfunction

  // Hamming position of data bit j: non-power-of-two positions, ascending
  function automatic int ecc_data_pos(input int j);
    int cnt, p;
    cnt = 0;
    p   = 0;
    for (int q = 1; q < 128; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (cnt == j) p = q;
        cnt++;
      end
    end
    return p;
  endfunction

  // data bits whose position has bit k set
  function automatic logic [63:0] ecc_dmask(input int dw, input int k);
    logic [63:0] m;
    m = '0;
    for (int j = 0; j < dw; j++)
      if (((ecc_data_pos(j) >> k) & 1) != 0) m = m | (64'(1) << j);
    return m;
  endfunction

  // codeword positions 1..cw-1 that have bit k set
  function automatic logic [127:0] ecc_cover(input int cw, input int k);
    logic [127:0] m;
    m = '0;
    for (int q = 1; q < cw; q++)
      if (((q >> k) & 1) != 0) m = m | (128'(1) << q);
    return m;
  endfunction

endpackage

// File: rtl/ecc_stream_channel_if.sv
// Stream-in / stream-out bus of the ECC channel plus the statistics port.
interface ecc_stream_channel_if import ecc_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  localparam int CW = ecc_cw(DATA_WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [CW-1:0]         inj_mask;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_corr;
  logic                  out_uncorr;
  logic                  cnt_clr;
  logic [CNT_WIDTH-1:0]  corr_cnt;
  logic [CNT_WIDTH-1:0]  uncorr_cnt;

  modport slave (
    input  in_valid, in_data, inj_mask, out_ready, cnt_clr,
    output in_ready, out_valid, out_data, out_corr, out_uncorr, corr_cnt, uncorr_cnt
  );

  modport master (
    output in_valid, in_data, inj_mask, out_ready, cnt_clr,
    input  in_ready, out_valid, out_data, out_corr, out_uncorr, corr_cnt, uncorr_cnt
  );
endinterface

// File: rtl/ecc_secded_enc.sv
// Combinational extended-Hamming encoder: bit 0 overall parity, check bits at
// power-of-two positions, data bits packed into the rest LSB first.
module ecc_secded_enc import ecc_pkg::*; #(
  parameter  int DATA_WIDTH = 8,
  localparam int PW         = ecc_pw(DATA_WIDTH),
  localparam int CW         = ecc_cw(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CW-1:0]         cw_o
);
  logic [PW-1:0] chk;

  for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_data
    assign cw_o[ecc_data_pos(j)] = data_i[j];
  end

  for (genvar k = 0; k < PW; k++) begin : g_chk
    localparam logic [DATA_WIDTH-1:0] DM = DATA_WIDTH'(ecc_dmask(DATA_WIDTH, k));
    assign chk[k]         = ^(data_i & DM);
    assign cw_o[1 << k]   = chk[k];
  end

  // overall parity from sources, avoiding a loop through cw_o itself
  assign cw_o[0] = ^data_i ^ ^chk;
endmodule

// File: rtl/ecc_stream_channel.sv
// 3-stage SECDED stream channel: encode+inject, syndrome, correct/flag, with
// a single global advance enable and saturating error counters.
module ecc_stream_channel import ecc_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic                 clk,
  input logic                 rst,
  ecc_stream_channel_if.slave bus
);
  localparam int PW     = ecc_pw(DATA_WIDTH);
  localparam int CW     = ecc_cw(DATA_WIDTH);
  localparam int STAGES = 3;

  logic                  adv;
  logic [STAGES:1]       vld_q;
  logic [CW-1:0]         cw_enc, s1_cw_q, s2_cw_q, cw_fix;
  logic [PW-1:0]         syn_d, s2_syn_q;
  logic                  s2_par_q;
  logic [DATA_WIDTH-1:0] dec_data, out_data_q;
  ecc_stat_e             stat_d, stat_q;
  logic [CNT_WIDTH-1:0]  corr_cnt_d, corr_cnt_q, uncorr_cnt_d, uncorr_cnt_q;
  logic                  hs;

  assign adv          = !vld_q[STAGES] || bus.out_ready;
  assign bus.in_ready = adv;

  ecc_secded_enc #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
    .data_i (bus.in_data),
    .cw_o   (cw_enc)
  );

  for (genvar k = 0; k < PW; k++) begin : g_syn
    localparam logic [CW-1:0] COV = CW'(ecc_cover(CW, k));
    assign syn_d[k] = ^(s1_cw_q & COV);
  end

  always_comb begin
    stat_d = ECC_CLEAN;
    cw_fix = s2_cw_q;
    if (s2_par_q) begin
      // s=0 flips the overall parity bit, which carries no data
      if (int'(s2_syn_q) <= CW - 1) begin
        stat_d = ECC_CORR;
        cw_fix = s2_cw_q ^ (CW'(1) << s2_syn_q);
      end else begin
        stat_d = ECC_UNCORR;
      end
    end else if (s2_syn_q != '0) begin
      stat_d = ECC_UNCORR;
    end
  end

  for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_extract
    assign dec_data[j] = cw_fix[ecc_data_pos(j)];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= '0;
      s1_cw_q    <= '0;
      s2_cw_q    <= '0;
      s2_syn_q   <= '0;
      s2_par_q   <= 1'b0;
      out_data_q <= '0;
      stat_q     <= ECC_CLEAN;
    end else if (adv) begin
      vld_q <= {vld_q[STAGES-1:1], bus.in_valid};
      if (bus.in_valid) s1_cw_q <= cw_enc ^ bus.inj_mask;
      if (vld_q[1]) begin
        s2_cw_q  <= s1_cw_q;
        s2_syn_q <= syn_d;
        s2_par_q <= ^s1_cw_q;
      end
      if (vld_q[2]) begin
        out_data_q <= dec_data;
        stat_q     <= stat_d;
      end
    end
  end

  assign hs = vld_q[STAGES] && bus.out_ready;

  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (bus.cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (hs) begin
      if (stat_q == ECC_CORR && corr_cnt_q != '1)
        corr_cnt_d = corr_cnt_q + CNT_WIDTH'(1);
      if (stat_q == ECC_UNCORR && uncorr_cnt_q != '1)
        uncorr_cnt_d = uncorr_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign bus.out_valid  = vld_q[STAGES];
  assign bus.out_data   = out_data_q;
  assign bus.out_corr   = (stat_q == ECC_CORR);
  assign bus.out_uncorr = (stat_q == ECC_UNCORR);
  assign bus.corr_cnt   = corr_cnt_q;
  assign bus.uncorr_cnt = uncorr_cnt_q;
endmodule

// File: tb/tb_ecc_stream_channel.sv
// Directed bench for ecc_stream_channel: a 16-bit-counter instance for the
// datapath/stall/reset cases and a 4-bit-counter instance for saturation.
module tb_ecc_stream_channel;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ecc_stream_channel_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) a_if ();
  ecc_stream_channel_if #(.DATA_WIDTH(8), .CNT_WIDTH(4))  b_if ();

  ecc_stream_channel #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut_a (
    .clk (clk), .rst (rst), .bus (a_if.slave)
  );
  ecc_stream_channel #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_b (
    .clk (clk), .rst (rst), .bus (b_if.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // one beat through A with out_ready=1; checks latency, payload and flags
  task automatic run_a(input logic [7:0] d, input logic [12:0] m,
                       input logic [7:0] exp_d, input logic exp_c, input logic exp_u);
    a_if.in_valid = 1'b1;
    a_if.in_data  = d;
    a_if.inj_mask = m;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      if (c == 1) a_if.in_valid = 1'b0;
      if (c < 3) chk("lat_early_valid", a_if.out_valid, 0);
    end
    chk("lat3_valid", a_if.out_valid, 1);
    chk("out_data", a_if.out_data, exp_d);
    chk("out_corr", a_if.out_corr, exp_c);
    chk("out_uncorr", a_if.out_uncorr, exp_u);
    cyc();
    chk("drained_valid", a_if.out_valid, 0);
  endtask

  int sent, got;
  logic [7:0] held;
  logic prev_stall, acc;

  initial begin
    rst = 1'b1;
    a_if.in_valid = 0; a_if.in_data = '0; a_if.inj_mask = '0;
    a_if.out_ready = 1; a_if.cnt_clr = 0;
    b_if.in_valid = 0; b_if.in_data = '0; b_if.inj_mask = '0;
    b_if.out_ready = 1; b_if.cnt_clr = 0;
    cyc(); cyc();
    chk("rst_out_valid", a_if.out_valid, 0);
    chk("rst_out_data", a_if.out_data, 0);
    chk("rst_out_corr", a_if.out_corr, 0);
    chk("rst_out_uncorr", a_if.out_uncorr, 0);
    chk("rst_corr_cnt", a_if.corr_cnt, 0);
    chk("rst_uncorr_cnt", a_if.uncorr_cnt, 0);
    chk("rst_b_corr_cnt", b_if.corr_cnt, 0);
    rst = 1'b0;
    cyc();

    // clean, single-data, overall-parity, double, out-of-range, top position
    run_a(8'hA5, 13'h0000, 8'hA5, 0, 0);
    chk("clean_corr_cnt", a_if.corr_cnt, 0);
    chk("clean_uncorr_cnt", a_if.uncorr_cnt, 0);
    run_a(8'h3C, 13'h0008, 8'h3C, 1, 0);
    chk("pos3_corr_cnt", a_if.corr_cnt, 1);
    run_a(8'h3C, 13'h0001, 8'h3C, 1, 0);
    chk("par_corr_cnt", a_if.corr_cnt, 2);
    run_a(8'h3C, 13'h0018, 8'h3D, 0, 1);
    chk("dbl_uncorr_cnt", a_if.uncorr_cnt, 1);
    chk("dbl_corr_cnt", a_if.corr_cnt, 2);
    run_a(8'hA5, 13'h0112, 8'hA5, 0, 1);
    chk("synhi_uncorr_cnt", a_if.uncorr_cnt, 2);
    run_a(8'h5A, 13'h1000, 8'h5A, 1, 0);
    chk("pos12_corr_cnt", a_if.corr_cnt, 3);

    // stream 1..8 with out_ready low on cycles 3..9
    sent = 0; got = 0; prev_stall = 0; held = '0;
    for (int c = 0; c < 40; c++) begin
      a_if.out_ready = !(c >= 3 && c <= 9);
      a_if.in_valid  = (sent < 8);
      a_if.in_data   = 8'(sent + 1);
      a_if.inj_mask  = '0;
      #1;
      if (prev_stall) chk("stall_hold", a_if.out_data, held);
      if (a_if.out_valid && a_if.out_ready) begin
        if (got < 8) begin
          chk("stream_order", a_if.out_data, got + 1);
          chk("stream_flags", {a_if.out_corr, a_if.out_uncorr}, 0);
        end else begin
          chk("stream_extra", a_if.out_valid, 0);
        end
        got++;
      end
      prev_stall = a_if.out_valid && !a_if.out_ready;
      held = a_if.out_data;
      acc  = a_if.in_valid && a_if.in_ready;
      @(posedge clk);
      if (acc) sent++;
      @(negedge clk);
    end
    a_if.in_valid = 0; a_if.out_ready = 1;
    chk("stream_sent", sent, 8);
    chk("stream_got", got, 8);

    // reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      a_if.in_valid = 1;
      a_if.in_data  = 8'(8'h11 * (i + 1));
      cyc();
    end
    chk("inflight_valid", a_if.out_valid, 1);
    rst = 1'b1;
    a_if.in_data = 8'h77;
    #1;
    chk("rst_mid_valid", a_if.out_valid, 0);
    cyc();
    chk("rst_hold_valid", a_if.out_valid, 0);
    rst = 1'b0;
    a_if.in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("no_stale_valid", a_if.out_valid, 0);
    end
    chk("post_rst_corr_cnt", a_if.corr_cnt, 0);
    run_a(8'h5A, 13'h0000, 8'h5A, 0, 0);

    // saturation on the 4-bit counter instance
    b_if.in_valid = 1; b_if.in_data = 8'hC3; b_if.inj_mask = 13'h0008;
    for (int i = 0; i < 20; i++) cyc();
    b_if.in_valid = 0;
    for (int i = 0; i < 5; i++) cyc();
    chk("sat_corr_cnt", b_if.corr_cnt, 15);
    chk("sat_uncorr_cnt", b_if.uncorr_cnt, 0);
    b_if.in_valid = 1; b_if.in_data = 8'h42; b_if.inj_mask = 13'h0008;
    cyc();
    b_if.in_valid = 0;
    cyc(); cyc();
    chk("clr_beat_valid", b_if.out_valid, 1);
    chk("clr_beat_data", b_if.out_data, 8'h42);
    chk("clr_beat_corr", b_if.out_corr, 1);
    b_if.cnt_clr = 1;
    cyc();
    b_if.cnt_clr = 0;
    chk("clr_corr_cnt", b_if.corr_cnt, 0);
    cyc();
    chk("clr_corr_cnt_hold", b_if.corr_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
